cv32e40p_alu_perm_fault_detector: RTL and testbench
===================================================

// Module: cv32e40p_alu_perm_fault_detector
// PURPOSE
// - Upstream of the faulty-ALU decoder. Turns per-cycle ALU disagreement reports from the voter into sticky permanent-fault flags (one per ALU replica).
// - Drives the 4-bit faulty-ALU vector that the decoder uses to select 3 of the 4 ALUs.
// - Each ALU has a leaky-bucket error counter. Transient upsets drain away; repeated errors cross a threshold and latch the ALU as permanently faulty.
// PARAMETERS
// - CNT_W      5   width of each per-ALU error counter; saturates at 2**CNT_W-1
// - INC_STEP   4   amount added to an ALU's counter on an error cycle
// - DEC_STEP   1   amount subtracted from an ALU's counter on a clean cycle
// - THRESHOLD  16  counter value at or above which the ALU is declared permanently faulty
// PORTS
// - clk_i                    in   1      core clock
// - rst_i                    in   1      reset, asynchronous, active-high
// - valid_i                  in   1      voter produced a result this cycle
// - err_alu_i                in   4      bit i = ALU i disagreed with the voted result (sampled only when valid_i=1)
// - active_alu_i             in   4      bit i = ALU i is in the voting set (decoder output, 1 = clocked)
// - clear_i                  in   1      clears all counters and flags (recovery/self-test)
// - permanent_faulty_alu_o   out  4      sticky fault flags, one per ALU; feeds the decoder
// - new_fault_o              out  1      one-cycle pulse when any flag goes 0->1
// - multi_err_o              out  1      one-cycle pulse: valid_i with >=2 active ALUs in error
// - err_cnt_o                out  4*CNT_W  counters, ALU i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
// - Reset: all counters = 0, permanent_faulty_alu_o = 4'b0000, new_fault_o = 0, multi_err_o = 0.
// - All outputs are registered. A flag rises on the cycle after the valid_i cycle whose update makes cnt >= THRESHOLD.
// - Effective error vector: e = err_alu_i & active_alu_i & ~permanent_faulty_alu_o. Errors on inactive or already-faulty ALUs are ignored.
// - Priority each cycle: clear_i > multi-error > normal update.
// - clear_i=1:
//   - counters = 0, flags = 0, both pulses = 0.
//   - Any simultaneous valid_i update is discarded.
// - Multi-error: valid_i=1 and popcount(e) >= 2.
//   - The vote is untrustworthy, so no counter changes.
//   - multi_err_o = 1 next cycle.
// - Normal update (valid_i=1, popcount(e) <= 1), for each ALU i that is active and not flagged:
//   - e[i]=1: cnt = min(cnt + INC_STEP, 2**CNT_W-1). Compute in CNT_W+1 bits; no wrap.
//   - e[i]=0: cnt = max(cnt - DEC_STEP, 0). No underflow.
// - valid_i=0: counters hold.
// - Inactive or flagged ALUs: counters hold (frozen) in all cases.
// - Flag set: when the updated cnt >= THRESHOLD and the flag is 0, set flag[i] and pulse new_fault_o for 1 cycle. The flag is sticky until clear_i or rst_i.
// - Two flags can never set in the same cycle, because a single error per cycle is guaranteed by the multi-error rule.
// - rst_i mid-operation: immediate asynchronous return to reset values. No state is retained.
// TESTING
// - Reset: assert rst_i mid-count (cnt0=12) -> all outputs 0 asynchronously, err_cnt_o=0 after release.
// - Threshold: active=0111, 4 valid cycles with err=0001 -> cnt0 = 4,8,12,16. Flag[0]=1 and new_fault_o=1 the cycle after the 4th; 5th error leaves cnt0=16.
// - Leak: err=0001, then 3 clean valid cycles -> cnt0 = 4,3,2,1. Then 4 more clean cycles -> cnt0 = 0, held at 0. No flag.
// - Multi-error: active=0111, err=0011 valid -> multi_err_o pulses, all counters unchanged. Same stimulus with active=0001 -> normal single-error update of ALU0.
// - Gating: err=1000 with active=0111 for 10 cycles -> cnt3 stays 0. Flagged ALU0 with err=0001 -> cnt0 frozen at 16, no new_fault_o.
// - Clear and saturation: drive cnt1 to 31 (CNT_W=5, THRESHOLD raised to 32 for this test) -> holds at 31. Then clear_i together with valid err=0010 -> all counters/flags 0 next cycle.

Source files
------------

// File: rtl/cv32e40p_alu_perm_fault_detector.sv
// cv32e40p_alu_perm_fault_detector: leaky-bucket error counters latching sticky permanent-fault flags per ALU replica
module cv32e40p_alu_perm_fault_detector #(
  parameter int CNT_W     = 5,
  parameter int INC_STEP  = 4,
  parameter int DEC_STEP  = 1,
  parameter int THRESHOLD = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [3:0]         err_alu_i,
  input  logic [3:0]         active_alu_i,
  input  logic               clear_i,
  output logic [3:0]         permanent_faulty_alu_o,
  output logic               new_fault_o,
  output logic               multi_err_o,
  output logic [4*CNT_W-1:0] err_cnt_o
);
  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'(2**CNT_W-1);
  logic [3:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0] e, upd, set;
  logic multi;
  assign e     = err_alu_i & active_alu_i & ~permanent_faulty_alu_o;
  assign multi = valid_i && ($countones(e) >= 2);
  assign upd   = {4{valid_i & ~multi}} & active_alu_i & ~permanent_faulty_alu_o;
  for (genvar i = 0; i < 4; i++) begin : g_alu
    logic [CNT_W:0] sum;
    assign sum = {1'b0, cnt[i]} + (CNT_W+1)'(INC_STEP);
    assign cnt_nxt[i] = !upd[i] ? cnt[i] :
                        e[i] ? (sum > CNT_MAX ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0]) :
                        (cnt[i] > CNT_W'(DEC_STEP) ? cnt[i] - CNT_W'(DEC_STEP) : '0);
    assign set[i] = upd[i] && ({1'b0, cnt_nxt[i]} >= (CNT_W+1)'(THRESHOLD));
  end
  assign err_cnt_o = cnt;
  // Counters, sticky flags and pulses; clear wins over any same-cycle vote
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      cnt                    <= '0;
      permanent_faulty_alu_o <= '0;
      new_fault_o            <= 1'b0;
      multi_err_o            <= 1'b0;
    end else begin
      cnt                    <= cnt_nxt;
      permanent_faulty_alu_o <= permanent_faulty_alu_o | set;
      new_fault_o            <= |set;
      multi_err_o            <= multi;
    end
  end
endmodule

// File: tb/tb_cv32e40p_alu_perm_fault_detector.sv
// tb_cv32e40p_alu_perm_fault_detector: directed and random checks against a behavioural model
module tb_cv32e40p_alu_perm_fault_detector;
  logic clk = 0, rst = 1, valid = 0, clr = 0;
  logic [3:0] err = 0, act = 0;
  logic [3:0] pf0, pf1;
  logic nf0, nf1, me0, me1;
  logic [19:0] ec0, ec1;
  int total = 0, bad = 0;
  int m_cnt[2][4];
  bit m_flag[2][4];
  bit m_new[2], m_multi[2];

  always #5 clk = ~clk;

  cv32e40p_alu_perm_fault_detector dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .err_alu_i(err), .active_alu_i(act), .clear_i(clr),
    .permanent_faulty_alu_o(pf0), .new_fault_o(nf0), .multi_err_o(me0), .err_cnt_o(ec0));

  cv32e40p_alu_perm_fault_detector #(.THRESHOLD(32)) dut_s (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .err_alu_i(err), .active_alu_i(act), .clear_i(clr),
    .permanent_faulty_alu_o(pf1), .new_fault_o(nf1), .multi_err_o(me1), .err_cnt_o(ec1));

  function automatic int th(input int k);
    return k == 1 ? 32 : 16;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_new[k] = 0;
      m_multi[k] = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[k][i] = 0;
        m_flag[k][i] = 0;
      end
    end
  endfunction

  function automatic void model(input bit v, input logic [3:0] er, input logic [3:0] ac, input bit cl);
    if (cl) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      bit e[4];
      for (int i = 0; i < 4; i++) begin
        e[i] = er[i] && ac[i] && !m_flag[k][i];
        n += int'(e[i]);
      end
      m_multi[k] = v && n >= 2;
      m_new[k] = 0;
      if (v && n < 2)
        for (int i = 0; i < 4; i++)
          if (ac[i] && !m_flag[k][i]) begin
            if (e[i]) m_cnt[k][i] = (m_cnt[k][i] + 4 > 31) ? 31 : m_cnt[k][i] + 4;
            else      m_cnt[k][i] = (m_cnt[k][i] - 1 < 0) ? 0 : m_cnt[k][i] - 1;
            if (m_cnt[k][i] >= th(k)) begin
              m_flag[k][i] = 1;
              m_new[k] = 1;
            end
          end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic [3:0] f;
      logic [19:0] c;
      for (int i = 0; i < 4; i++) begin
        f[i] = m_flag[k][i];
        c[i*5 +: 5] = 5'(m_cnt[k][i]);
      end
      chk($sformatf("%s_d%0d_flag", tag, k), {28'd0, k == 1 ? pf1 : pf0}, {28'd0, f});
      chk($sformatf("%s_d%0d_new", tag, k), {31'd0, k == 1 ? nf1 : nf0}, {31'd0, m_new[k]});
      chk($sformatf("%s_d%0d_multi", tag, k), {31'd0, k == 1 ? me1 : me0}, {31'd0, m_multi[k]});
      chk($sformatf("%s_d%0d_cnt", tag, k), {12'd0, k == 1 ? ec1 : ec0}, {12'd0, c});
    end
  endtask

  task automatic step(input bit v, input logic [3:0] er, input logic [3:0] ac, input bit cl, input string tag);
    valid = v;
    err = er;
    act = ac;
    clr = cl;
    @(posedge clk);
    model(v, er, ac, cl);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk) rst = 0;
    for (int j = 0; j < 3; j++) step(1, 4'b0001, 4'b0111, 0, "pre_rst");
    chk("pre_rst_cnt0", {27'd0, ec0[4:0]}, 32'd12);
    @(negedge clk) rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_cnt", {12'd0, ec0}, 32'd0);
    @(negedge clk) rst = 0;
    #1;
    check_all("post_rst");
    for (int j = 1; j <= 4; j++) begin
      step(1, 4'b0001, 4'b0111, 0, "thr");
      chk("thr_cnt0", {27'd0, ec0[4:0]}, 32'(4 * j));
    end
    chk("thr_flag0", {31'd0, pf0[0]}, 32'd1);
    chk("thr_new", {31'd0, nf0}, 32'd1);
    step(1, 4'b0001, 4'b0111, 0, "thr5");
    chk("thr5_cnt0", {27'd0, ec0[4:0]}, 32'd16);
    chk("thr5_new", {31'd0, nf0}, 32'd0);
    step(0, 4'b0000, 4'b0111, 1, "clr");
    step(1, 4'b0001, 4'b0111, 0, "leak_err");
    for (int j = 3; j >= 1; j--) begin
      step(1, 4'b0000, 4'b0111, 0, "leak");
      chk("leak_cnt0", {27'd0, ec0[4:0]}, 32'(j));
    end
    for (int j = 0; j < 4; j++) step(1, 4'b0000, 4'b0111, 0, "leak_zero");
    chk("leak_floor", {27'd0, ec0[4:0]}, 32'd0);
    chk("leak_noflag", {28'd0, pf0}, 32'd0);
    step(1, 4'b0001, 4'b0111, 0, "multi_pre");
    step(1, 4'b0011, 4'b0111, 0, "multi");
    chk("multi_pulse", {31'd0, me0}, 32'd1);
    chk("multi_hold", {27'd0, ec0[4:0]}, 32'd4);
    step(1, 4'b0011, 4'b0001, 0, "single");
    chk("single_pulse", {31'd0, me0}, 32'd0);
    chk("single_cnt0", {27'd0, ec0[4:0]}, 32'd8);
    step(0, 4'b0000, 4'b0000, 1, "clr2");
    for (int j = 0; j < 10; j++) step(1, 4'b1000, 4'b0111, 0, "gate3");
    chk("gate3_cnt3", {27'd0, ec0[19:15]}, 32'd0);
    for (int j = 0; j < 4; j++) step(1, 4'b0001, 4'b1111, 0, "fz_pre");
    for (int j = 0; j < 3; j++) step(1, 4'b0001, 4'b1111, 0, "frozen");
    chk("frozen_cnt0", {27'd0, ec0[4:0]}, 32'd16);
    chk("frozen_new", {31'd0, nf0}, 32'd0);
    step(0, 4'b0000, 4'b0000, 1, "clr3");
    for (int j = 0; j < 9; j++) step(1, 4'b0010, 4'b0010, 0, "sat");
    chk("sat_cnt1", {27'd0, ec1[9:5]}, 32'd31);
    chk("sat_noflag", {28'd0, pf1}, 32'd0);
    step(1, 4'b0010, 4'b0010, 1, "clr_valid");
    chk("clr_cnt_s", {12'd0, ec1}, 32'd0);
    chk("clr_flag", {28'd0, pf0}, 32'd0);
    for (int j = 0; j < 400; j++) begin
      logic [3:0] er;
      er = ($urandom_range(0, 2) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      step($urandom_range(0, 3) != 0, er, 4'($urandom) | 4'b0001, $urandom_range(0, 47) == 0, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
